// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_MUL_WAIT = 2'b01,
    S_DIV_WAIT = 2'b10,
    S_DONE     = 2'b11
  } state_t;

  // Architected result of a divide by zero: HI = dividend, LO = all ones.
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } md_req_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequences one MULT/MULTU/DIV/DIVU from EX through the external mul/div units,
// stalls EX until the result is in, then issues a single-cycle HI/LO write.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall_req,
  output logic        busy,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_annul,
  output logic        div_signed,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  md_req_t          req_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      req_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (flush) begin
      // Killed instruction: abandon whatever was in flight and its result.
      state <= S_IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_q <= '{op: req_op, a: src_a, b: src_b};
            if (!op_is_div(req_op)) begin
              state <= S_MUL_WAIT;
              cnt   <= CNT_W'(MUL_LAT - 1);
            end else if (src_b == '0) begin
              state <= S_DONE;
              hi_q  <= src_a;
              lo_q  <= DIV0_LO;
            end else begin
              state <= S_DIV_WAIT;
            end
          end
        end
        S_MUL_WAIT: begin
          if (cnt == '0) begin
            hi_q  <= mul_result[63:32];
            lo_q  <= mul_result[31:0];
            state <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DIV_WAIT: begin
          if (div_ready) begin
            hi_q  <= div_result[63:32];
            lo_q  <= div_result[31:0];
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // EX still shows the finished op here; it must not re-issue.
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stall rises in the request cycle itself, before the state register moves.
  assign stall_req = !rst && !flush &&
                     ((state == S_IDLE && req_valid) ||
                      state == S_MUL_WAIT || state == S_DIV_WAIT);
  assign busy      = (state != S_IDLE);
  assign hilo_we   = (state == S_DONE) && !flush;
  assign div_start = (state == S_DIV_WAIT) && !flush;
  assign div_annul = (state == S_DIV_WAIT) && flush;

  assign mul_signed = req_q.op[0];
  assign mul_ina    = req_q.a;
  assign mul_inb    = req_q.b;
  assign div_signed = req_q.op[0];
  assign div_opa    = req_q.a;
  assign div_opb    = req_q.b;
  assign hi_wdata   = hi_q;
  assign lo_wdata   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed + randomized bench for muldiv_ctrl with behavioural mul/div units.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        stall_req, busy, mul_signed, div_start, div_annul, div_signed, hilo_we;
  logic [31:0] mul_ina, mul_inb, div_opa, div_opb, hi_wdata, lo_wdata;
  logic [63:0] mul_result, div_result, mul_q;
  logic        div_ready;

  int n_chk = 0;
  int n_fail = 0;
  int we_cnt = 0;
  int dcnt = 0;
  int div_lat = 32;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_op(req_op),
    .src_a(src_a), .src_b(src_b), .stall_req(stall_req), .busy(busy),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
    .div_start(div_start), .div_annul(div_annul), .div_signed(div_signed),
    .div_opa(div_opa), .div_opb(div_opb), .div_result(div_result), .div_ready(div_ready),
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
  );

  function automatic logic [63:0] mul_ref(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = s ? {{32{a[31]}}, a} : {32'b0, a};
    sb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return sa * sb;
  endfunction

  function automatic logic [63:0] div_ref(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Multiplier: product valid MUL_LAT-1 cycles after the operands settle.
  always @(posedge clk) mul_q <= mul_ref(mul_signed, mul_ina, mul_inb);
  assign mul_result = mul_q;

  // Divider: ready after div_lat cycles of div_start, result only while ready.
  always @(posedge clk) dcnt <= div_start ? dcnt + 1 : 0;
  assign div_ready  = div_start && (dcnt == div_lat);
  assign div_result = div_ready ? div_ref(div_signed, div_opa, div_opb) : 64'hDEAD_BEEF_DEAD_BEEF;

  always @(negedge clk) if (hilo_we === 1'b1) we_cnt <= we_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " stall_req"}, stall_req, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " div_start"}, div_start, 0);
    chk({tag, " div_annul"}, div_annul, 0);
    chk({tag, " hilo_we"}, hilo_we, 0);
    chk({tag, " mul ops"}, {mul_signed, mul_ina, mul_inb}, 0);
    chk({tag, " div ops"}, {div_signed, div_opa, div_opb}, 0);
    chk({tag, " wdata"}, {hi_wdata, lo_wdata}, 0);
  endtask

  // Called just after a posedge with the DUT idle; cycle 0 is the request cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input bit hold, input string tag);
    int stall_end, we_cyc, w0;
    bit is_div, real_div;
    logic [63:0] exp;
    is_div   = op[1];
    real_div = is_div && (b != 32'd0);
    div_lat  = lat;
    if (!is_div) begin
      stall_end = MUL_LAT; we_cyc = MUL_LAT + 1; exp = mul_ref(op[0], a, b);
    end else if (!real_div) begin
      stall_end = 0; we_cyc = 1; exp = {a, 32'hFFFF_FFFF};
    end else begin
      stall_end = lat + 1; we_cyc = lat + 2; exp = div_ref(op[0], a, b);
    end
    w0 = we_cnt;
    req_valid = 1'b1; req_op = op; src_a = a; src_b = b;
    for (int c = 0; c <= we_cyc; c++) begin
      @(negedge clk);
      chk($sformatf("%s c%0d stall", tag, c), stall_req, (c <= stall_end));
      chk($sformatf("%s c%0d we", tag, c), hilo_we, (c == we_cyc));
      chk($sformatf("%s c%0d div_start", tag, c), div_start,
          (real_div && c >= 1 && c <= stall_end));
      if (!is_div && c >= 1 && c <= stall_end)
        chk($sformatf("%s c%0d mul ops", tag, c), {mul_signed, mul_ina, mul_inb}, {op[0], a, b});
      if (real_div && c >= 1 && c <= stall_end)
        chk($sformatf("%s c%0d div ops", tag, c), {div_signed, div_opa, div_opb}, {op[0], a, b});
      if (c == we_cyc)
        chk({tag, " hi/lo"}, {hi_wdata, lo_wdata}, exp);
      @(posedge clk); #1;
      if (!hold) req_valid = 1'b0;
    end
    chk({tag, " one write"}, we_cnt - w0, 1);
  endtask

  initial begin
    int w0;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    // Reset: outputs 0 even with a request pending
    req_valid = 1'b1; req_op = OP_DIV; src_a = 32'd9; src_b = 32'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, 1'b0, "mult -2*3");
    run_op(OP_DIVU, 32'd100, 32'd7, 32, 1'b0, "divu 100/7");
    run_op(OP_DIV, 32'd5, 32'd0, 0, 1'b0, "div by 0");
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 3, 1'b0, "div -7/2");

    // Flush at cycle 10 of a divide
    w0 = we_cnt;
    div_lat = 40;
    req_valid = 1'b1; req_op = OP_DIV; src_a = 32'd1000; src_b = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush annul", div_annul, 1);
    chk("flush start", div_start, 0);
    chk("flush stall", stall_req, 0);
    chk("flush we", hilo_we, 0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("post-flush busy", busy, 0);
    chk("post-flush annul", div_annul, 0);
    repeat (45) @(posedge clk);
    #1 chk("flush no write", we_cnt - w0, 0);

    // Flush together with a request in IDLE drops it
    req_valid = 1'b1; req_op = OP_MULTU; src_a = 32'd4; src_b = 32'd4; flush = 1'b1;
    @(negedge clk);
    chk("flush+req stall", stall_req, 0);
    @(posedge clk); #1 flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("flush+req busy", busy, 0);

    // Flush in DONE suppresses the write
    w0 = we_cnt;
    req_valid = 1'b1; req_op = OP_DIVU; src_a = 32'd77; src_b = 32'd0;
    @(posedge clk); #1 req_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush done we", hilo_we, 0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush done busy", busy, 0);
    chk("flush done no write", we_cnt - w0, 0);
    @(posedge clk); #1;

    // Back-to-back with req_valid held across DONE
    w0 = we_cnt;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 1'b1, "b2b multu");
    run_op(OP_DIVU, 32'd50, 32'd6, 4, 1'b0, "b2b divu");
    chk("b2b two writes", we_cnt - w0, 2);

    // Async reset mid-DIV_WAIT
    w0 = we_cnt;
    div_lat = 40;
    req_valid = 1'b1; req_op = OP_DIV; src_a = 32'd1234; src_b = 32'd11;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_zero("async rst");
    @(posedge clk); #1 rst = 1'b0;
    chk("rst no write", we_cnt - w0, 0);
    run_op(OP_MULTU, 32'd123456, 32'd789, 0, 1'b0, "post-rst multu");

    // Randomized ops against the reference functions
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 4) == 0) ? 32'd0 :
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if (rop == OP_DIV && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      run_op(rop, ra, rb, $urandom_range(0, 6), 1'b0, $sformatf("rand%0d op%0d", i, rop));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
